program_loader: RTL and testbench
=================================

# program_loader

Upstream stage of the 8-bit processor. It receives a byte stream over a valid/ready handshake and assembles it into 20-bit instruction words. The words go into a 16-entry writable instruction store, which the processor's 4-bit `pc` reads combinationally in place of the fixed program memory. The loader holds the processor in reset while a load is in progress and releases it only after a load completes with a valid checksum.

## Interface
- `ADDR_W`, 4, instruction address width (matches `pc`)
- `INSTR_W`, 20, instruction word width
- `DEPTH`, 16, instruction store entries (2**ADDR_W)
- `clk`  in  1  system clock, rising edge
- `reset_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `load_start`  in  1  single-cycle pulse; begins, or restarts, a load
- `byte_valid`  in  1  `byte_data` is valid
- `byte_data`  in  8  stream byte
- `byte_ready`  out  1  loader accepts a byte this cycle
- `pc`  in  4  processor read address
- `instruction`  out  20  instruction at `pc`, combinational
- `cpu_reset`  out  1  active-high reset to the processor
- `load_done`  out  1  last load succeeded
- `load_error`  out  1  last load failed
- `word_count`  out  5  number of valid words in the store (0..16)

## Operation
- Stream format after `load_start`:
  - count byte N, legal range 1..16;
  - then N×3 instruction bytes, each word sent as B0 = instr[7:0], B1 = instr[15:8], B2 = {4'b0, instr[19:16]};
  - then one checksum byte equal to the XOR of all 3N instruction bytes. The count byte is not included.
- A byte transfer occurs on a rising edge where `byte_valid && byte_ready`.
- States: IDLE, COUNT, B0, B1, B2, CHECK, DONE, ERROR.
- IDLE: entered from reset. `cpu_reset`=1. A `load_start` pulse moves to COUNT.
- COUNT: an accepted byte of 0 or >16 moves to ERROR. Otherwise store N, set the write address to 0, clear the XOR accumulator and `word_count`, and move to B0.
- B0 / B1: latch the byte, XOR it into the accumulator, advance to the next state.
- B2:
  - If byte[7:4] ≠ 0, move to ERROR.
  - Otherwise write {byte[3:0], B1, B0} to mem[addr], XOR the byte into the accumulator, increment addr and `word_count`.
  - Move to CHECK if `word_count`+1 == N, else back to B0.
- CHECK: if the byte equals the accumulator, move to DONE; otherwise move to ERROR.
- DONE: `load_done`=1, `cpu_reset`=0. Hold until `load_start`.
- ERROR: `load_error`=1, `cpu_reset`=1. Hold until `load_start`.
- `load_start` in any state:
  - moves to COUNT, clears `load_done`, `load_error` and `word_count`, and sets `cpu_reset`=1;
  - a load already in progress is aborted. Words it has written stay in memory but are masked by `word_count`.
- `byte_ready` = state ∈ {COUNT, B0, B1, B2, CHECK} && !`load_start`. It is 0 in IDLE, DONE and ERROR.
- Read port: `instruction` = (`pc` < `word_count`) ? mem[`pc`] : 20'h0. Entries that were never loaded, or are stale, read as 0.
- The memory array needs no reset. `word_count`=0 masks it.

## Timing
- Reset (`reset_n`=0, asynchronous) sets:
  - state=IDLE;
  - `cpu_reset`=1, `load_done`=0, `load_error`=0, `word_count`=0, `byte_ready`=0;
  - `instruction`=0 for every `pc`.
- The instruction write is visible on `instruction` the cycle after the B2 byte is accepted.
- At the edge where a good checksum byte is accepted, the state moves to DONE. From the following cycle `load_done`=1 and `cpu_reset`=0, and the processor's first FETCH can start on the next edge.
- Errors are detected on the edge of the offending byte. `load_error`=1 from the next cycle.
- Throughput is one byte per cycle when `byte_valid` is held high. Gaps in `byte_valid` stall the FSM without changing any state.
- `load_start` and `byte_valid` in the same cycle: `load_start` wins and the byte is not consumed (`byte_ready`=0).
- `reset_n` asserted mid-load aborts immediately. A new `load_start` is required afterwards.
- Addresses never wrap: N ≤ 16, so the write address stops at 16 with `word_count`=16.

## Test plan
- Reset: assert `reset_n`=0 mid-operation. Expect `cpu_reset`=1, `byte_ready`=0, `word_count`=0, and `instruction`=0 for `pc`=0..15.
- Good 2-word load:
  - send `load_start`, then bytes 02, 34, 12, 05, 78, 56, 0A, checksum 07;
  - expect `load_done`=1, `cpu_reset`=0, `word_count`=2;
  - expect `pc`=0 → 0x51234, `pc`=1 → 0xA5678, `pc`=2 → 0x00000.
- Bad checksum: same stream with checksum 08. Expect `load_error`=1, `cpu_reset`=1, `load_done`=0, `byte_ready`=0.
- Illegal stream:
  - count 00 → `load_error`=1 after one byte;
  - count 11 → same;
  - count 01, then 00 00 15 → `load_error`=1 on the B2 byte, `word_count`=0.
- Abort and backpressure:
  - start the 2-word load with idle gaps in `byte_valid`;
  - after the first word, pulse `load_start` in the same cycle as a valid byte; that byte is not consumed;
  - load 01, FF, FF, 0F, checksum 0F;
  - expect `word_count`=1, `pc`=0 → 0xFFFFF, `pc`=1 → 0.
- Full load: 16 words with instr[i] = {4'h0, i, i}, i.e. bytes i, i, 00 per word, followed by the correct checksum. Expect `word_count`=16 and `pc`=15 → 0x00F0F.

Source files
------------

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : program_loader
//  Brief    : Byte-stream loader that assembles 20-bit instruction words into
//             a 16-entry instruction store, verifies an XOR checksum and holds
//             the processor in reset until a load completes cleanly.
//  Revision : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 20,
    parameter int DEPTH   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load_start,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    input  logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instruction,
    output logic               cpu_reset,
    output logic               load_done,
    output logic               load_error,
    output logic [ADDR_W:0]    word_count
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_COUNT = 3'd1;
    localparam logic [2:0] c_ST_B0    = 3'd2;
    localparam logic [2:0] c_ST_B1    = 3'd3;
    localparam logic [2:0] c_ST_B2    = 3'd4;
    localparam logic [2:0] c_ST_CHECK = 3'd5;
    localparam logic [2:0] c_ST_DONE  = 3'd6;
    localparam logic [2:0] c_ST_ERROR = 3'd7;

    localparam logic [7:0] c_MAX_COUNT = 8'(DEPTH);

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [ADDR_W:0]    r_n;
    logic [ADDR_W:0]    r_word_count;
    logic [7:0]         r_acc;
    logic [7:0]         r_b0;
    logic [7:0]         r_b1;
    logic [INSTR_W-1:0] r_mem [DEPTH];

    logic               w_in_load;
    logic               w_xfer;
    logic               w_count_ok;
    logic               w_b2_ok;
    logic               w_write;
    logic               w_last_word;

    // A load is in progress in any of the byte-consuming states; a
    // simultaneous load_start takes priority and refuses the byte.
    assign w_in_load   = (r_state == c_ST_COUNT) || (r_state == c_ST_B0) ||
                         (r_state == c_ST_B1)    || (r_state == c_ST_B2) ||
                         (r_state == c_ST_CHECK);
    assign byte_ready  = w_in_load && !load_start;
    assign w_xfer      = byte_valid && byte_ready;
    assign w_count_ok  = (byte_data != 8'd0) && (byte_data <= c_MAX_COUNT);
    assign w_b2_ok     = (byte_data[7:4] == 4'd0);
    assign w_write     = w_xfer && (r_state == c_ST_B2) && w_b2_ok;
    assign w_last_word = ((r_word_count + 1'b1) == r_n);

    // Status outputs decode directly from the registered state.
    assign load_done   = (r_state == c_ST_DONE);
    assign load_error  = (r_state == c_ST_ERROR);
    assign cpu_reset   = (r_state != c_ST_DONE);
    assign word_count  = r_word_count;

    // Entries at or beyond word_count are stale or never loaded; mask them.
    assign instruction = ({1'b0, pc} < r_word_count) ? r_mem[pc] : '0;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: load_start restarts from any state, otherwise the
    // FSM only moves on an accepted byte so gaps in byte_valid stall it.
    always_comb begin
        w_next_state = r_state;
        if (load_start) begin
            w_next_state = c_ST_COUNT;
        end else if (w_xfer) begin
            case (r_state)
                c_ST_COUNT: w_next_state = w_count_ok ? c_ST_B0 : c_ST_ERROR;
                c_ST_B0:    w_next_state = c_ST_B1;
                c_ST_B1:    w_next_state = c_ST_B2;
                c_ST_B2: begin
                    if (!w_b2_ok) begin
                        w_next_state = c_ST_ERROR;
                    end else if (w_last_word) begin
                        w_next_state = c_ST_CHECK;
                    end else begin
                        w_next_state = c_ST_B0;
                    end
                end
                c_ST_CHECK: w_next_state = (byte_data == r_acc) ? c_ST_DONE : c_ST_ERROR;
                default:    w_next_state = r_state;
            endcase
        end
    end

    // Byte latches, checksum accumulator and word counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_n          <= '0;
            r_word_count <= '0;
            r_acc        <= 8'd0;
            r_b0         <= 8'd0;
            r_b1         <= 8'd0;
        end else if (load_start) begin
            r_word_count <= '0;
        end else if (w_xfer) begin
            case (r_state)
                c_ST_COUNT: begin
                    if (w_count_ok) begin
                        r_n          <= byte_data[ADDR_W:0];
                        r_acc        <= 8'd0;
                        r_word_count <= '0;
                    end
                end
                c_ST_B0: begin
                    r_b0  <= byte_data;
                    r_acc <= r_acc ^ byte_data;
                end
                c_ST_B1: begin
                    r_b1  <= byte_data;
                    r_acc <= r_acc ^ byte_data;
                end
                c_ST_B2: begin
                    if (w_b2_ok) begin
                        r_acc        <= r_acc ^ byte_data;
                        r_word_count <= r_word_count + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Instruction store write; the write address is the current word count,
    // which never exceeds DEPTH-1 at a write because the count byte is <= DEPTH.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_word_count[ADDR_W-1:0]] <= {byte_data[3:0], r_b1, r_b0};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_program_loader
//  Brief    : Scoreboard bench for program_loader. Stimulus queues the expected
//             end-of-load (or reset) snapshot; a monitor pops and compares it
//             whenever load_done/load_error rises or reset_n falls.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load_start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [3:0]  pc;
    logic [19:0] instruction;
    logic        cpu_reset;
    logic        load_done;
    logic        load_error;
    logic [4:0]  word_count;

    typedef struct packed {
        logic             done;
        logic             err;
        logic             cpu_rst;
        logic             rdy;
        logic [4:0]       wc;
        logic             chk_load;
        logic [7:0]       nbytes;
        logic [15:0][19:0] mem;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    program_loader #(.ADDR_W(4), .INSTR_W(20), .DEPTH(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_start  (load_start),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .pc          (pc),
        .instruction (instruction),
        .cpu_reset   (cpu_reset),
        .load_done   (load_done),
        .load_error  (load_error),
        .word_count  (word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: owns pc; snapshots the DUT at each outcome event.
    // ------------------------------------------------------------------
    initial begin : monitor
        logic prev_rst, prev_done, prev_err, trig;
        int   nbytes, ne_since;
        exp_t e;
        pc = 4'd0;
        prev_rst = 1'b1; prev_done = 1'b0; prev_err = 1'b0;
        nbytes = 0; ne_since = 0;
        forever begin
            @(negedge clk);
            ne_since++;
            trig = (!reset_n && prev_rst) || (load_done && !prev_done) ||
                   (load_error && !prev_err);
            if (trig) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_event: done=%b error=%b reset_n=%b with nothing expected",
                             load_done, load_error, reset_n);
                end else begin
                    e = q.pop_front();
                    chk("load_done",  32'(load_done),  32'(e.done));
                    chk("load_error", 32'(load_error), 32'(e.err));
                    chk("cpu_reset",  32'(cpu_reset),  32'(e.cpu_rst));
                    chk("byte_ready", 32'(byte_ready), 32'(e.rdy));
                    chk("word_count", 32'(word_count), 32'(e.wc));
                    if (e.chk_load) begin
                        chk("bytes_accepted", 32'(nbytes), 32'(e.nbytes));
                        chk("outcome_latency", 32'(ne_since), 32'd1);
                    end
                    for (int i = 0; i < 16; i++) begin
                        pc = 4'(i);
                        #0.2;
                        checks++;
                        if (instruction !== e.mem[i]) begin
                            errors++;
                            $display("FAIL instruction[pc=%0d]: got %h expected %h", i, instruction, e.mem[i]);
                        end
                    end
                    pc = 4'd0;
                end
            end
            prev_rst  = reset_n;
            prev_done = load_done;
            prev_err  = load_error;
            if (load_start) nbytes = 0;
            if (byte_valid && byte_ready) begin
                nbytes++;
                ne_since = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic push(input logic done, input logic err, input logic [4:0] wc,
                        input logic chk_load, input logic [7:0] nb,
                        input logic [15:0][19:0] mem);
        exp_t e;
        e.done = done; e.err = err; e.cpu_rst = !done; e.rdy = 1'b0;
        e.wc = wc; e.chk_load = chk_load; e.nbytes = nb; e.mem = mem;
        q.push_back(e);
    endtask

    task automatic start();
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        byte_data  = b;
        byte_valid = 1'b1;
        @(negedge clk);
        while (!byte_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) begin
            checks++; errors++;
            $display("FAIL byte_ready_timeout: byte %h got ready=0 expected 1", b);
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic gap(input int k);
        byte_valid = 1'b0;
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL outcome_timeout: pending=%0d expected 0", q.size());
            q.delete();
        end
        @(posedge clk); #1;
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin : stimulus
        logic [15:0][19:0] m;
        logic [7:0]        b;
        reset_n = 1'b1; load_start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;

        // Power-on reset.
        m = '0;
        push(1'b0, 1'b0, 5'd0, 1'b0, 8'd0, m);
        #3 reset_n = 1'b0;
        #20 reset_n = 1'b1;
        @(posedge clk); #1;
        drain();

        // Good 2-word load.
        m = '0; m[0] = 20'h51234; m[1] = 20'hA5678;
        push(1'b1, 1'b0, 5'd2, 1'b1, 8'd8, m);
        start();
        send(8'h02); send(8'h34); send(8'h12); send(8'h05);
        send(8'h78); send(8'h56); send(8'h0A); send(8'h07);
        drain();

        // Bad checksum: words already written remain counted.
        push(1'b0, 1'b1, 5'd2, 1'b1, 8'd8, m);
        start();
        send(8'h02); send(8'h34); send(8'h12); send(8'h05);
        send(8'h78); send(8'h56); send(8'h0A); send(8'h08);
        drain();

        // Illegal counts and illegal B2 byte.
        m = '0;
        push(1'b0, 1'b1, 5'd0, 1'b1, 8'd1, m);
        start(); send(8'h00);
        drain();
        push(1'b0, 1'b1, 5'd0, 1'b1, 8'd1, m);
        start(); send(8'h11);
        drain();
        push(1'b0, 1'b1, 5'd0, 1'b1, 8'd4, m);
        start(); send(8'h01); send(8'h00); send(8'h00); send(8'h15);
        drain();

        // Reset in the middle of a load.
        push(1'b0, 1'b0, 5'd0, 1'b0, 8'd0, m);
        start(); send(8'h02); send(8'h34); send(8'h12); send(8'h05); send(8'h78);
        reset_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        drain();

        // Backpressure gaps, then abort colliding with a valid byte.
        m = '0; m[0] = 20'hFFFFF;
        push(1'b1, 1'b0, 5'd1, 1'b1, 8'd5, m);
        start();
        send(8'h02); gap(2); send(8'h34); gap(1); send(8'h12); send(8'h05); gap(1);
        load_start = 1'b1; byte_valid = 1'b1; byte_data = 8'h78;
        @(posedge clk); #1;
        load_start = 1'b0; byte_valid = 1'b0;
        send(8'h01); send(8'hFF); send(8'hFF); send(8'h0F); send(8'h0F);
        drain();

        // Full 16-word load; every word XORs to zero, so checksum is 00.
        m = '0;
        for (int i = 0; i < 16; i++) m[i] = {4'h0, 8'(i), 8'(i)};
        push(1'b1, 1'b0, 5'd16, 1'b1, 8'd50, m);
        start();
        send(8'h10);
        for (int i = 0; i < 16; i++) begin
            b = 8'(i);
            send(b); send(b); send(8'h00);
        end
        send(8'h00);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
